id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Parametrised ID/EX pipeline stage that replaces the fixed-width ID/EX register. It adds a valid/ready handshake on both sides, flush on taken branch, and load-use hazard detection with single-bubble insertion. It also keeps a sticky illegal-opcode flag and a saturating stall counter. It sits between the decode/control unit and the execute stage, and registers all datapath values and control bits decoded in ID.

## Interface
Parameters:
- XLEN, 64, datapath width (pc, register data, immediate)
- ILEN, 32, instruction width
- RA_W, 5, register-address width
- ALUC_W, 10, width of {funct7, funct3} ALU control field
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  ID holds a valid instruction
- ready_out  out  1  stage accepts ID payload this cycle
- pc_in, rd1_in, rd2_in, imm_in  in  XLEN each  ID datapath values
- instr_in  in  ILEN  raw instruction
- rs1_in, rs2_in, wr_in  in  RA_W each  register addresses
- aluc_in  in  ALUC_W  ALU control field
- aluop_in  in  2  ALUOp
- ctl_in  in  6  {alusrc, branch, memwrite, memread, memtoreg, regwrite}
- invop_in  in  1  decoder invalid-opcode flag
- flush  in  1  taken branch/redirect from EX
- valid_out  out  1  EX payload valid
- ready_in  in  1  EX accepts payload
- pc_out, rd1_out, rd2_out, imm_out, instr_out, rs1_out, rs2_out, wr_out, aluc_out, aluop_out, ctl_out  out  widths as inputs  registered payload
- hazard_stall  out  1  load-use bubble being inserted this cycle
- illegal_seen  out  1  sticky: an accepted instruction had invop_in=1
- stall_cnt  out  CNT_W  saturating count of hazard_stall cycles

## Operation
- Definitions:
  - advance = ready_in | ~valid_out
  - uses_rs2 = opcode (instr_in[6:0]) is R-type 0110011, store 0100011 or branch 1100011
  - hazard = valid_in & valid_out & ctl_out.memread & (wr_out != 0) & ((wr_out == rs1_in) | (uses_rs2 & (wr_out == rs2_in)))
- Per-cycle priority, highest first:
  1. flush: valid_out<=0; ctl_out, aluop_out <=0; ready_out=1, so the ID instruction is consumed and discarded; hazard_stall=0.
  2. advance & hazard: load a bubble (valid_out<=0, ctl_out<=0, aluop_out<=0); ready_out=0; hazard_stall=1; stall_cnt increments.
  3. advance & ~hazard: load all payload inputs; valid_out<=valid_in; ready_out=1.
  4. ~advance: hold every register; ready_out=0.
- Whenever valid_out is 0, ctl_out and aluop_out are forced to 0, so a bubble never writes memory or registers.
- illegal_seen is set when valid_in & ready_out & ~flush & invop_in. It is cleared only by reset.
- stall_cnt saturates at 2^CNT_W-1 and never wraps.
- A bubble clears valid_out, so the hazard drops the next cycle. Each load-use pair costs exactly one bubble.

## Timing
- Latency: one cycle from an accepted ID payload to the EX outputs.
- ready_out is combinational from valid_out, ctl_out, wr_out, ready_in, flush and the ID address/opcode inputs. No register sits on that path.
- Reset, asynchronous while low: every output register goes to 0, including valid_out, illegal_seen and stall_cnt. ready_out then evaluates to 1.
- Reset deasserts synchronously to clk. The first capture happens on the first rising edge after release.
- Reset asserted mid-stall: the bubble and the held payload are both lost. No instruction is replayed.
- flush and hazard in the same cycle: flush wins and the counter does not increment.
- flush while ~advance: flush still clears valid_out, because a flush kills the EX slot unconditionally.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants: OP_R 0110011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011
  - ctl bit-index constants
  - default XLEN
- Sub-module load_use_detect, purely combinational: computes uses_rs2 and hazard from the EX-side and ID-side fields.
- The top level contains only the payload register, the sticky flag and the counter.

## Test plan
- Reset: hold rst=0 with random inputs -> all outputs 0 and ready_out=1. Release, apply valid_in=1, pc_in=0x40 -> next edge pc_out=0x40, valid_out=1.
- Load-use: LW x5,0(x1) accepted, then ADD x6,x5,x2 at ID with ready_in=1 -> one cycle with hazard_stall=1, valid_out=0, ctl_out=0; ADD appears the following cycle; stall_cnt=1.
- No false hazard:
  - LW x0 followed by ADD x1,x0,x0 -> no stall.
  - LW x5 followed by ADDI x6,x7,1 -> no stall.
  - LW x5 followed by an I-type instruction with rs2 field=5 -> no stall.
- Backpressure: ready_in=0 while valid_out=1 for 3 cycles -> outputs stable and ready_out=0. Raise ready_in -> the next payload loads.
- Flush: flush=1 while valid_out=1, a hazard is present and ready_in=0 -> valid_out=0 next edge, ready_out=1, stall_cnt unchanged.
- Illegal and saturation:
  - Accept an instruction with invop_in=1 -> illegal_seen=1 and persists until reset.
  - With CNT_W=2, force 5 hazard cycles -> stall_cnt=3.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, control-bundle bit positions
// and default datapath width used by the pipeline stages.
package riscv_pkg;

    localparam int XLEN_DEF = 64;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ctl = {alusrc, branch, memwrite, memread, memtoreg, regwrite}
    localparam int CTL_W        = 6;
    localparam int CTL_REGWRITE = 0;
    localparam int CTL_MEMTOREG = 1;
    localparam int CTL_MEMREAD  = 2;
    localparam int CTL_MEMWRITE = 3;
    localparam int CTL_BRANCH   = 4;
    localparam int CTL_ALUSRC   = 5;

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX
// and the instruction currently presented by ID.
module load_use_detect
    import riscv_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            valid_id,
    input  logic [6:0]      opcode,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    input  logic            valid_ex,
    input  logic            memread_ex,
    input  logic [RA_W-1:0] wr_ex,
    output logic            hazard
);

    logic uses_rs2;
    logic rs1_hit;
    logic rs2_hit;

    assign uses_rs2 = reads_rs2(opcode);
    assign rs1_hit  = (wr_ex == rs1);
    assign rs2_hit  = uses_rs2 && (wr_ex == rs2);

    // x0 is never a real producer, so a load to x0 cannot stall
    assign hazard = valid_id && valid_ex && memread_ex
                    && (wr_ex != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, branch flush,
// single-bubble load-use stall, sticky illegal flag and stall counter.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ILEN   = 32,
    parameter int RA_W   = 5,
    parameter int ALUC_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [XLEN-1:0]   rd1_in,
    input  logic [XLEN-1:0]   rd2_in,
    input  logic [XLEN-1:0]   imm_in,
    input  logic [ILEN-1:0]   instr_in,
    input  logic [RA_W-1:0]   rs1_in,
    input  logic [RA_W-1:0]   rs2_in,
    input  logic [RA_W-1:0]   wr_in,
    input  logic [ALUC_W-1:0] aluc_in,
    input  logic [1:0]        aluop_in,
    input  logic [CTL_W-1:0]  ctl_in,
    input  logic              invop_in,
    input  logic              flush,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   rd1_out,
    output logic [XLEN-1:0]   rd2_out,
    output logic [XLEN-1:0]   imm_out,
    output logic [ILEN-1:0]   instr_out,
    output logic [RA_W-1:0]   rs1_out,
    output logic [RA_W-1:0]   rs2_out,
    output logic [RA_W-1:0]   wr_out,
    output logic [ALUC_W-1:0] aluc_out,
    output logic [1:0]        aluop_out,
    output logic [CTL_W-1:0]  ctl_out,
    output logic              hazard_stall,
    output logic              illegal_seen,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic advance;
    logic hazard;
    logic kill;

    load_use_detect #(.RA_W(RA_W)) u_hazard (
        .valid_id   (valid_in),
        .opcode     (instr_in[6:0]),
        .rs1        (rs1_in),
        .rs2        (rs2_in),
        .valid_ex   (valid_out),
        .memread_ex (ctl_out[CTL_MEMREAD]),
        .wr_ex      (wr_out),
        .hazard     (hazard)
    );

    assign advance      = ready_in || !valid_out;
    assign hazard_stall = !flush && advance && hazard;
    assign ready_out    = flush || (advance && !hazard);
    assign kill         = flush || hazard_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out    <= 1'b0;
            pc_out       <= '0;
            rd1_out      <= '0;
            rd2_out      <= '0;
            imm_out      <= '0;
            instr_out    <= '0;
            rs1_out      <= '0;
            rs2_out      <= '0;
            wr_out       <= '0;
            aluc_out     <= '0;
            aluop_out    <= '0;
            ctl_out      <= '0;
            illegal_seen <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            if (kill) begin
                valid_out <= 1'b0;
                ctl_out   <= '0;
                aluop_out <= '0;
            end else if (advance) begin
                valid_out <= valid_in;
                pc_out    <= pc_in;
                rd1_out   <= rd1_in;
                rd2_out   <= rd2_in;
                imm_out   <= imm_in;
                instr_out <= instr_in;
                rs1_out   <= rs1_in;
                rs2_out   <= rs2_in;
                wr_out    <= wr_in;
                aluc_out  <= aluc_in;
                // an empty slot must never carry write enables
                aluop_out <= valid_in ? aluop_in : 2'b00;
                ctl_out   <= valid_in ? ctl_in : '0;
            end
            if (valid_in && ready_out && !flush && invop_in)
                illegal_seen <= 1'b1;
            if (hazard_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed ID traffic, expected EX
// payloads queued at issue and popped by an output monitor.
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int XLEN = 64;
    localparam int CNT_W = 2;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [5:0] C_LW   = 6'b100111;
    localparam logic [5:0] C_ADD  = 6'b000001;
    localparam logic [5:0] C_ADDI = 6'b100001;
    localparam logic [5:0] C_SW   = 6'b101000;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [5:0]      ctl;
        logic [4:0]      wr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid_in = 1'b0;
    logic ready_out;
    logic [XLEN-1:0] pc_in = '0, rd1_in = '0, rd2_in = '0, imm_in = '0;
    logic [31:0] instr_in = '0;
    logic [4:0] rs1_in = '0, rs2_in = '0, wr_in = '0;
    logic [9:0] aluc_in = '0;
    logic [1:0] aluop_in = '0;
    logic [5:0] ctl_in = '0;
    logic invop_in = 1'b0;
    logic flush = 1'b0;
    logic valid_out;
    logic ready_in = 1'b1;
    logic [XLEN-1:0] pc_out, rd1_out, rd2_out, imm_out;
    logic [31:0] instr_out;
    logic [4:0] rs1_out, rs2_out, wr_out;
    logic [9:0] aluc_out;
    logic [1:0] aluop_out;
    logic [5:0] ctl_out;
    logic hazard_stall, illegal_seen;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int cnt_exp = 0;
    exp_t exp_q[$];

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .ready_out(ready_out),
        .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .instr_in(instr_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
        .wr_in(wr_in), .aluc_in(aluc_in), .aluop_in(aluop_in),
        .ctl_in(ctl_in), .invop_in(invop_in), .flush(flush),
        .valid_out(valid_out), .ready_in(ready_in),
        .pc_out(pc_out), .rd1_out(rd1_out), .rd2_out(rd2_out),
        .imm_out(imm_out), .instr_out(instr_out), .rs1_out(rs1_out),
        .rs2_out(rs2_out), .wr_out(wr_out), .aluc_out(aluc_out),
        .aluop_out(aluop_out), .ctl_out(ctl_out),
        .hazard_stall(hazard_stall), .illegal_seen(illegal_seen),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, op};
    endfunction

    // Present one instruction at ID; optionally queue its expected EX view.
    task automatic set_id(input logic [XLEN-1:0] pc, input logic [6:0] op,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [5:0] ctl, input logic inv, input bit push);
        exp_t e;
        valid_in = 1'b1;
        pc_in    = pc;
        rd1_in   = pc + 64'd1;
        rd2_in   = pc + 64'd2;
        imm_in   = {59'b0, rs2};
        instr_in = mk(op, rd, rs1, rs2);
        rs1_in   = rs1;
        rs2_in   = rs2;
        wr_in    = rd;
        aluc_in  = 10'h155;
        aluop_in = 2'b10;
        ctl_in   = ctl;
        invop_in = inv;
        if (push) begin
            e.pc = pc; e.instr = mk(op, rd, rs1, rs2);
            e.ctl = ctl; e.wr = rd;
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic [XLEN-1:0] pc, input logic [6:0] op,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [5:0] ctl, input logic inv, output int stalls);
        bit acc = 0;
        bit st;
        stalls = 0;
        set_id(pc, op, rd, rs1, rs2, ctl, inv, 1'b1);
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            st = 0;
            if (ready_out) acc = 1;
            else if (hazard_stall) begin stalls++; st = 1; end
            @(posedge clk); #1;
            if (st) chk("bubble_valid", {63'b0, valid_out}, 64'd0);
        end
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout pc %0h not accepted", pc);
        end
        valid_in = 1'b0;
        invop_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic add_stall(input int n);
        cnt_exp = (cnt_exp + n > 3) ? 3 : cnt_exp + n;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (!valid_out)
                chk("bubble_ctl", {56'b0, aluop_out, ctl_out}, 64'd0);
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out pc %0h", pc_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_pc", pc_out, e.pc);
                    chk("out_instr", {32'b0, instr_out}, {32'b0, e.instr});
                    chk("out_ctl", {58'b0, ctl_out}, {58'b0, e.ctl});
                    chk("out_wr", {59'b0, wr_out}, {59'b0, e.wr});
                end
            end
        end
    end

    initial begin
        int s;
        // reset with random inputs
        repeat (3) begin
            @(posedge clk); #1;
            valid_in = 1'($urandom); flush = 1'($urandom);
            ready_in = 1'($urandom); pc_in = {$urandom, $urandom};
            instr_in = $urandom; ctl_in = 6'($urandom);
            wr_in = 5'($urandom); rs1_in = 5'($urandom);
            invop_in = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_valid", {63'b0, valid_out}, 64'd0);
        chk("rst_pc", pc_out, 64'd0);
        chk("rst_ctl", {58'b0, ctl_out}, 64'd0);
        chk("rst_cnt", {62'b0, stall_cnt}, 64'd0);
        chk("rst_ill", {63'b0, illegal_seen}, 64'd0);
        chk("rst_ready", {63'b0, ready_out}, 64'd1);
        chk("rst_hz", {63'b0, hazard_stall}, 64'd0);
        valid_in = 0; flush = 0; ready_in = 1; invop_in = 0;
        rst = 1'b1;
        @(posedge clk); #1;

        // first capture
        send(64'h40, OP_IMM, 5'd0, 5'd0, 5'd0, C_ADDI, 1'b0, s);
        chk("first_pc", pc_out, 64'h40);
        chk("first_valid", {63'b0, valid_out}, 64'd1);

        // load-use: LW x5,0(x1); ADD x6,x5,x2
        send(64'h44, OP_LOAD, 5'd5, 5'd1, 5'd0, C_LW, 1'b0, s);
        send(64'h48, OP_R, 5'd6, 5'd5, 5'd2, C_ADD, 1'b0, s);
        add_stall(1);
        chk("lu_stalls", 64'(s), 64'd1);
        chk("lu_cnt", {62'b0, stall_cnt}, 64'(cnt_exp));

        // no false hazard: load to x0
        send(64'h4c, OP_LOAD, 5'd0, 5'd1, 5'd0, C_LW, 1'b0, s);
        send(64'h50, OP_R, 5'd1, 5'd0, 5'd0, C_ADD, 1'b0, s);
        chk("x0_stalls", 64'(s), 64'd0);
        // unrelated I-type
        send(64'h54, OP_LOAD, 5'd5, 5'd1, 5'd0, C_LW, 1'b0, s);
        send(64'h58, OP_IMM, 5'd6, 5'd7, 5'd1, C_ADDI, 1'b0, s);
        chk("addi_stalls", 64'(s), 64'd0);
        // I-type whose rs2 field matches
        send(64'h5c, OP_LOAD, 5'd5, 5'd1, 5'd0, C_LW, 1'b0, s);
        send(64'h60, OP_IMM, 5'd6, 5'd7, 5'd5, C_ADDI, 1'b0, s);
        chk("irs2_stalls", 64'(s), 64'd0);
        // store data depends on load via rs2
        send(64'h64, OP_LOAD, 5'd5, 5'd1, 5'd0, C_LW, 1'b0, s);
        send(64'h68, OP_STORE, 5'd0, 5'd8, 5'd5, C_SW, 1'b0, s);
        add_stall(1);
        chk("sw_stalls", 64'(s), 64'd1);
        chk("sw_cnt", {62'b0, stall_cnt}, 64'(cnt_exp));

        // backpressure
        send(64'h100, OP_IMM, 5'd3, 5'd4, 5'd0, C_ADDI, 1'b0, s);
        ready_in = 1'b0;
        set_id(64'h104, OP_IMM, 5'd9, 5'd4, 5'd0, C_ADDI, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", {63'b0, ready_out}, 64'd0);
            chk("bp_pc", pc_out, 64'h100);
            chk("bp_valid", {63'b0, valid_out}, 64'd1);
            @(posedge clk); #1;
        end
        ready_in = 1'b1;
        @(negedge clk);
        chk("bp_release", {63'b0, ready_out}, 64'd1);
        @(posedge clk); #1;
        chk("bp_next_pc", pc_out, 64'h104);
        idle(1);

        // flush over a pending hazard while EX is stalled
        ready_in = 1'b0;
        send(64'h200, OP_LOAD, 5'd5, 5'd1, 5'd0, C_LW, 1'b0, s);
        set_id(64'h204, OP_R, 5'd6, 5'd5, 5'd2, C_ADD, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_ready", {63'b0, ready_out}, 64'd1);
        chk("fl_hz", {63'b0, hazard_stall}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0; invop_in = 1'b0;
        chk("fl_valid", {63'b0, valid_out}, 64'd0);
        chk("fl_cnt", {62'b0, stall_cnt}, 64'(cnt_exp));
        chk("fl_ill", {63'b0, illegal_seen}, 64'd0);
        void'(exp_q.pop_front());
        ready_in = 1'b1;

        // illegal opcode
        send(64'h300, OP_IMM, 5'd2, 5'd3, 5'd0, C_ADDI, 1'b1, s);
        chk("ill_set", {63'b0, illegal_seen}, 64'd1);

        // saturation
        for (int k = 0; k < 4; k++) begin
            send(64'h400 + 64'(8 * k), OP_LOAD, 5'd5, 5'd1, 5'd0,
                 C_LW, 1'b0, s);
            send(64'h404 + 64'(8 * k), OP_R, 5'd6, 5'd5, 5'd2,
                 C_ADD, 1'b0, s);
            add_stall(1);
            chk("sat_stalls", 64'(s), 64'd1);
            chk("sat_cnt", {62'b0, stall_cnt}, 64'(cnt_exp));
        end
        chk("ill_keep", {63'b0, illegal_seen}, 64'd1);

        idle(3);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        // asynchronous reset clears sticky state
        #2 rst = 1'b0;
        #1;
        chk("rst2_ill", {63'b0, illegal_seen}, 64'd0);
        chk("rst2_cnt", {62'b0, stall_cnt}, 64'd0);
        chk("rst2_ready", {63'b0, ready_out}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
